// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipe: branch flush, load-use interlock, fixed-latency mult/div hold.
// Latency: hazard controls are combinational (same cycle); muldiv_done is registered, one cycle after the hold ends.
// Backpressure: asserts pc_stall/ifid_stall/idex_bubble upstream; it has no input it must wait on.
module hazard_ctrl #(
  parameter int MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_muldiv,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        muldiv_done,
  output logic [15:0] stall_count
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  // Counter preload: the entry cycle is the first of MD_LATENCY stall cycles.
  localparam logic [3:0] MD_CNT_INIT = 4'(MD_LATENCY - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_muldiv_done;
  logic [15:0] r_stall_count;

  logic w_load_use;
  logic w_md_entry;
  logic w_stall;
  logic w_flush;

  // Register 0 is hardwired zero, so a load targeting it is never a real dependency.
  assign w_load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Hazard priority decode: branch flush beats load-use beats mult/div entry.
  always_comb begin
    w_md_entry = 1'b0;
    w_stall    = 1'b0;
    w_flush    = 1'b0;
    if (r_state == MD_WAIT) begin
      w_stall = 1'b1;
    end else if (ex_branch_taken) begin
      // The ID instruction is on the wrong path, so a mult/div there is dropped.
      w_flush = 1'b1;
    end else if (w_load_use) begin
      w_stall = 1'b1;
    end else if (id_muldiv && !r_muldiv_done) begin
      // A done pulse means this mult/div already served its hold and must advance.
      w_stall    = 1'b1;
      w_md_entry = 1'b1;
    end
  end

  // Controls are forced low while reset is held, regardless of the inputs.
  assign pc_stall    = rst_n && w_stall;
  assign ifid_stall  = rst_n && w_stall;
  assign ifid_flush  = rst_n && w_flush;
  assign idex_bubble = rst_n && (w_stall || w_flush);
  assign muldiv_done = rst_n && r_muldiv_done;
  assign stall_count = rst_n ? r_stall_count : 16'd0;

  // Mult/div hold FSM: count down the remaining stall cycles, pulse done on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_cnt         <= 4'd0;
      r_muldiv_done <= 1'b0;
    end else begin
      r_muldiv_done <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_md_entry) begin
            r_state <= MD_WAIT;
            r_cnt   <= MD_CNT_INIT;
          end
        end
        MD_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state       <= RUN;
            r_muldiv_done <= 1'b1;
          end
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  // Performance counter of PC-hold cycles; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= 16'd0;
    end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MD_LATENCY=4.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
// Output vector order: {pc_stall, ifid_stall, ifid_flush, idex_bubble, muldiv_done}.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_muldiv;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        muldiv_done;
  logic [15:0] stall_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_STALL = 5'b11010;
  localparam logic [4:0] O_FLUSH = 5'b00110;
  localparam logic [4:0] O_DONE  = 5'b00001;

  hazard_ctrl #(.MD_LATENCY(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_muldiv       (id_muldiv),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .muldiv_done     (muldiv_done),
    .stall_count     (stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_muldiv = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    #1;
    obs = {pc_stall, ifid_stall, ifid_flush, idex_bubble, muldiv_done};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    checks++;
    assert (stall_count === exp) else begin
      failures++;
      $error("FAIL %s stall_count observed=%0h expected=%0h", tag, stall_count, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Reset: outputs zero even with hazards present on the inputs.
    #12;
    chk_out("reset_idle", O_IDLE);
    chk_cnt("reset_cnt", 16'd0);
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_muldiv = 1'b1;
    chk_out("reset_forced", O_IDLE);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    chk_out("post_reset_idle", O_IDLE);
    chk_cnt("post_reset_cnt", 16'd0);

    // Load-use on rs: single stall cycle.
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    chk_out("lu_rs", O_STALL);
    tick();
    idle_inputs();
    chk_out("lu_rs_next", O_IDLE);
    chk_cnt("lu_rs_cnt", 16'd1);

    // Load to $0 never stalls.
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    chk_out("lu_r0", O_IDLE);
    tick();
    idle_inputs();
    chk_cnt("lu_r0_cnt", 16'd1);

    // rt match only counts when rt is a source.
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
    chk_out("lu_rt_unused", O_IDLE);
    id_uses_rt = 1'b1;
    chk_out("lu_rt_used", O_STALL);
    tick();
    idle_inputs();
    chk_cnt("lu_rt_cnt", 16'd2);

    // Mult/div hold, id_muldiv held: 4 stalls, done on cycle 5, then back-to-back entry.
    id_muldiv = 1'b1;
    chk_out("md_c1", O_STALL);
    tick(); chk_out("md_c2", O_STALL);
    tick(); chk_out("md_c3", O_STALL);
    tick(); chk_out("md_c4", O_STALL);
    tick(); chk_out("md_c5_done", O_DONE);
    chk_cnt("md_cnt", 16'd6);
    tick(); chk_out("md2_c1", O_STALL);
    tick(); chk_out("md2_c2", O_STALL);
    tick(); chk_out("md2_c3", O_STALL);
    tick(); chk_out("md2_c4", O_STALL);
    tick(); chk_out("md2_done", O_DONE);
    chk_cnt("md2_cnt", 16'd10);
    idle_inputs();
    tick();
    chk_out("md2_after", O_IDLE);

    // Branch beats load-use and mult/div; FSM stays in RUN.
    ex_branch_taken = 1'b1; id_muldiv = 1'b1;
    ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
    chk_out("branch_prio", O_FLUSH);
    tick();
    idle_inputs();
    chk_out("branch_stay_run", O_IDLE);
    chk_cnt("branch_cnt", 16'd10);

    // Reset during the second MD_WAIT cycle.
    id_muldiv = 1'b1;
    chk_out("rmd_c1", O_STALL);
    tick(); chk_out("rmd_c2", O_STALL);
    tick(); chk_out("rmd_c3", O_STALL);
    rst_n = 1'b0;
    chk_out("rmd_in_reset", O_IDLE);
    chk_cnt("rmd_cnt_clear", 16'd0);
    tick();
    id_muldiv = 1'b0;
    rst_n = 1'b1;
    chk_out("rmd_release", O_IDLE);
    tick();
    chk_out("rmd_no_done", O_IDLE);
    id_muldiv = 1'b1;
    chk_out("fresh_c1", O_STALL);
    tick(); chk_out("fresh_c2", O_STALL);
    tick(); chk_out("fresh_c3", O_STALL);
    tick(); chk_out("fresh_c4", O_STALL);
    tick(); chk_out("fresh_done", O_DONE);
    idle_inputs();
    tick();
    chk_cnt("fresh_cnt", 16'd4);

    // Saturation: continuous load-use stall from count 4.
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    for (int i = 0; i < 65530; i++) tick();
    chk_cnt("sat_fffe", 16'hFFFE);
    tick();
    chk_cnt("sat_ffff", 16'hFFFF);
    for (int i = 0; i < 9; i++) tick();
    chk_cnt("sat_hold", 16'hFFFF);
    chk_out("sat_still_stall", O_STALL);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
